// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins by default; a burst counter hands fetch a slot when it waits too long.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                IReqF,
  input  logic [ADDR_W-1:0]   IAddrF,
  output logic [DATA_W-1:0]   IRdataF,
  output logic                IValidF,
  input  logic                DReqM,
  input  logic                DWeM,
  input  logic [ADDR_W-1:0]   DAddrM,
  input  logic [DATA_W-1:0]   DWdataM,
  input  logic [DATA_W/8-1:0] DByteEnM,
  output logic [DATA_W-1:0]   DRdataM,
  output logic                DValidM,
  output logic                MemReq,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWdata,
  output logic [DATA_W/8-1:0] MemByteEn,
  input  logic [DATA_W-1:0]   MemRdata,
  input  logic                MemReady,
  output logic                StallMemF,
  output logic                StallMemM
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] DMAX = 4'(MAX_D_BURST);

  typedef enum logic [1:0] {
    IDLE,
    I_WAIT,
    D_WAIT
  } state_t;

  state_t     state;
  logic [3:0] dcnt;
  logic       d_grant;
  logic       i_grant;
  logic       mem_done;

  always_comb begin
    d_grant = 1'b0;
    i_grant = 1'b0;
    if (state == IDLE) begin
      d_grant = DReqM && (!IReqF || (dcnt < DMAX));
      i_grant = !d_grant && IReqF;
    end
  end

  // MemReady only means something while a request is outstanding
  assign mem_done = MemReq && MemReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dcnt      <= 4'd0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWdata  <= '0;
      MemByteEn <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_grant) begin
            state     <= D_WAIT;
            MemReq    <= 1'b1;
            MemWe     <= DWeM;
            MemAddr   <= DAddrM;
            MemWdata  <= DWdataM;
            MemByteEn <= DByteEnM;
          end else if (i_grant) begin
            state     <= I_WAIT;
            MemReq    <= 1'b1;
            MemWe     <= 1'b0;
            MemAddr   <= IAddrF;
            MemWdata  <= '0;
            MemByteEn <= {BE_W{1'b1}};
          end
          if (i_grant || !IReqF) begin
            dcnt <= 4'd0;
          end else if (d_grant && (dcnt < DMAX)) begin
            dcnt <= dcnt + 4'd1;
          end
        end
        I_WAIT, D_WAIT: begin
          if (mem_done) begin
            state  <= IDLE;
            MemReq <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
        end
      endcase
    end
  end

  // A flushed fetch still finishes on the bus but never reports completion
  assign IValidF = (state == I_WAIT) && mem_done && IReqF;
  assign DValidM = (state == D_WAIT) && mem_done;
  assign IRdataF = MemRdata;
  assign DRdataM = MemRdata;

  assign StallMemF = IReqF && !IValidF;
  assign StallMemM = DReqM && !DValidM;

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    (MemReq && !MemReady) |=>
      (MemReq && $stable(MemAddr) && $stable(MemWe) &&
       $stable(MemWdata) && $stable(MemByteEn))
  );

  a_one_valid: assert property (
    @(posedge clk) disable iff (reset)
    !(IValidF && DValidM)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake, wait states,
// contention fairness, fetch flush and asynchronous reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        IReqF;
  logic [31:0] IAddrF;
  logic [31:0] IRdataF;
  logic        IValidF;
  logic        DReqM;
  logic        DWeM;
  logic [31:0] DAddrM;
  logic [31:0] DWdataM;
  logic [3:0]  DByteEnM;
  logic [31:0] DRdataM;
  logic        DValidM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRdata;
  logic        MemReady;
  logic        StallMemF;
  logic        StallMemM;

  int checks;
  int errors;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_BURST(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .IReqF(IReqF),
    .IAddrF(IAddrF),
    .IRdataF(IRdataF),
    .IValidF(IValidF),
    .DReqM(DReqM),
    .DWeM(DWeM),
    .DAddrM(DAddrM),
    .DWdataM(DWdataM),
    .DByteEnM(DByteEnM),
    .DRdataM(DRdataM),
    .DValidM(DValidM),
    .MemReq(MemReq),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWdata(MemWdata),
    .MemByteEn(MemByteEn),
    .MemRdata(MemRdata),
    .MemReady(MemReady),
    .StallMemF(StallMemF),
    .StallMemM(StallMemM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    DReqM = 1'b1;
    IReqF = 1'b0;
    #1;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rst_memreq got %0h want 0", MemReq); end
    checks++; if (MemWe !== 1'b0) begin errors++; $display("FAIL rst_memwe got %0h want 0", MemWe); end
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL rst_memaddr got %h want 0", MemAddr); end
    checks++; if (MemByteEn !== 4'h0) begin errors++; $display("FAIL rst_byteen got %h want 0", MemByteEn); end
    checks++; if (MemWdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", MemWdata); end
    checks++; if ({IValidF, DValidM} !== 2'b00) begin errors++; $display("FAIL rst_valids got %b want 00", {IValidF, DValidM}); end
    checks++; if ({StallMemF, StallMemM} !== 2'b01) begin errors++; $display("FAIL rst_stalls got %b want 01", {StallMemF, StallMemM}); end
    checks++; if (dut.dcnt !== 4'd0) begin errors++; $display("FAIL rst_dcnt got %0d want 0", dut.dcnt); end
    DReqM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle_ready();
    step();
    MemReady = 1'b1;
    MemRdata = 32'h1234_5678;
    #1;
    checks++; if ({MemReq, IValidF, DValidM} !== 3'b000) begin errors++; $display("FAIL idle_ready got %b want 000", {MemReq, IValidF, DValidM}); end
    step();
    MemReady = 1'b0;
    #1;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL idle_ready_memreq got %0h want 0", MemReq); end
  endtask

  task automatic test_single_fetch();
    step();
    IReqF    = 1'b1;
    IAddrF   = 32'h100;
    MemReady = 1'b1;
    MemRdata = 32'h0000_0013;
    #1;
    checks++; if ({StallMemF, MemReq, IValidF} !== 3'b100) begin errors++; $display("FAIL fetch_c0 got %b want 100", {StallMemF, MemReq, IValidF}); end
    step();
    #1;
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL fetch_memreq got %0h want 1", MemReq); end
    checks++; if (MemAddr !== 32'h100) begin errors++; $display("FAIL fetch_addr got %h want 100", MemAddr); end
    checks++; if ({MemWe, MemByteEn} !== 5'b0_1111) begin errors++; $display("FAIL fetch_we_be got %b want 01111", {MemWe, MemByteEn}); end
    checks++; if (IValidF !== 1'b1) begin errors++; $display("FAIL fetch_ivalid got %0h want 1", IValidF); end
    checks++; if (IRdataF !== 32'h13) begin errors++; $display("FAIL fetch_rdata got %h want 13", IRdataF); end
    checks++; if (StallMemF !== 1'b0) begin errors++; $display("FAIL fetch_stall got %0h want 0", StallMemF); end
    step();
    IReqF    = 1'b0;
    MemReady = 1'b0;
    #1;
    checks++; if ({MemReq, IValidF} !== 2'b00) begin errors++; $display("FAIL fetch_gap got %b want 00", {MemReq, IValidF}); end
  endtask

  task automatic test_store_wait();
    step();
    DReqM    = 1'b1;
    DWeM     = 1'b1;
    DAddrM   = 32'h2000;
    DWdataM  = 32'hDEAD_BEEF;
    DByteEnM = 4'b0011;
    MemReady = 1'b0;
    #1;
    checks++; if ({StallMemM, MemReq} !== 2'b10) begin errors++; $display("FAIL store_c0 got %b want 10", {StallMemM, MemReq}); end
    for (int k = 0; k < 4; k++) begin
      step();
      MemReady = (k == 3);
      if (k == 1) begin
        DAddrM  = 32'hFFFF_0000;
        DWdataM = 32'h0;
      end
      #1;
      checks++; if ({MemReq, MemWe, MemByteEn} !== 6'b11_0011) begin errors++; $display("FAIL store_ctl k=%0d got %b want 110011", k, {MemReq, MemWe, MemByteEn}); end
      checks++; if ({MemAddr, MemWdata} !== {32'h2000, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_hold k=%0d got %h %h want 2000 deadbeef", k, MemAddr, MemWdata); end
      checks++; if ({DValidM, StallMemM} !== ((k == 3) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL store_valid k=%0d got %b want %b", k, {DValidM, StallMemM}, (k == 3) ? 2'b10 : 2'b01); end
    end
    step();
    DReqM    = 1'b0;
    DWeM     = 1'b0;
    MemReady = 1'b0;
    #1;
    checks++; if ({MemReq, DValidM} !== 2'b00) begin errors++; $display("FAIL store_done got %b want 00", {MemReq, DValidM}); end
  endtask

  task automatic test_contention();
    bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int idx = 0;
    bit is_d;
    step();
    IReqF    = 1'b1;
    IAddrF   = 32'h100;
    DReqM    = 1'b1;
    DWeM     = 1'b0;
    DAddrM   = 32'h4000;
    MemReady = 1'b1;
    MemRdata = 32'h55;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      step();
      if (MemReq) begin
        is_d = (MemAddr == 32'h4000);
        checks++; if (is_d !== exp_d[idx]) begin errors++; $display("FAIL contention_order #%0d got d=%0d want d=%0d", idx, is_d, exp_d[idx]); end
        checks++; if ({DValidM, IValidF} !== {exp_d[idx], !exp_d[idx]}) begin errors++; $display("FAIL contention_valid #%0d got %b want %b", idx, {DValidM, IValidF}, {exp_d[idx], !exp_d[idx]}); end
        if (idx == 3) begin
          checks++; if (dut.dcnt !== 4'd4) begin errors++; $display("FAIL contention_dcnt_sat got %0d want 4", dut.dcnt); end
        end
        if (idx == 4) begin
          checks++; if (dut.dcnt !== 4'd0) begin errors++; $display("FAIL contention_dcnt_clr got %0d want 0", dut.dcnt); end
        end
        idx++;
      end
    end
    checks++; if (idx != 10) begin errors++; $display("FAIL contention_timeout got %0d grants want 10", idx); end
    step();
    IReqF    = 1'b0;
    DReqM    = 1'b0;
    MemReady = 1'b0;
    step();
    #1;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL contention_drain got %0h want 0", MemReq); end
  endtask

  task automatic test_flush();
    step();
    IReqF    = 1'b1;
    IAddrF   = 32'h300;
    MemReady = 1'b0;
    MemRdata = 32'hABCD_0000;
    step();
    IReqF = 1'b0;
    #1;
    checks++; if ({MemReq, StallMemF, IValidF} !== 3'b100) begin errors++; $display("FAIL flush_wait got %b want 100", {MemReq, StallMemF, IValidF}); end
    step();
    MemReady = 1'b1;
    DReqM    = 1'b1;
    DWeM     = 1'b0;
    DAddrM   = 32'h500;
    #1;
    checks++; if ({MemReq, IValidF, DValidM} !== 3'b100) begin errors++; $display("FAIL flush_done got %b want 100", {MemReq, IValidF, DValidM}); end
    checks++; if (MemAddr !== 32'h300) begin errors++; $display("FAIL flush_addr got %h want 300", MemAddr); end
    step();
    #1;
    checks++; if ({MemReq, IValidF, DValidM} !== 3'b000) begin errors++; $display("FAIL flush_idle got %b want 000", {MemReq, IValidF, DValidM}); end
    step();
    #1;
    checks++; if ({MemReq, MemWe, MemAddr} !== {2'b10, 32'h500}) begin errors++; $display("FAIL flush_next_d got %b %h want 10 500", {MemReq, MemWe}, MemAddr); end
    checks++; if ({DValidM, DRdataM} !== {1'b1, 32'hABCD_0000}) begin errors++; $display("FAIL flush_next_data got %0h %h want 1 abcd0000", DValidM, DRdataM); end
    step();
    DReqM    = 1'b0;
    MemReady = 1'b0;
  endtask

  task automatic test_async_reset();
    step();
    DReqM    = 1'b1;
    DWeM     = 1'b1;
    DAddrM   = 32'h600;
    DWdataM  = 32'h1;
    DByteEnM = 4'hF;
    MemReady = 1'b0;
    step();
    #1;
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL areset_pre got %0h want 1", MemReq); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({MemReq, MemWe, MemAddr} !== {2'b00, 32'h0}) begin errors++; $display("FAIL areset_async got %b %h want 00 0", {MemReq, MemWe}, MemAddr); end
    DReqM = 1'b0;
    DWeM  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dut.dcnt !== 4'd0) begin errors++; $display("FAIL areset_dcnt got %0d want 0", dut.dcnt); end
    step();
    IReqF    = 1'b1;
    IAddrF   = 32'h700;
    MemReady = 1'b1;
    MemRdata = 32'hCAFE;
    #1;
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL areset_idle got %0h want 0", MemReq); end
    step();
    #1;
    checks++; if ({IValidF, IRdataF, MemAddr} !== {1'b1, 32'hCAFE, 32'h700}) begin errors++; $display("FAIL areset_fetch got %0h %h %h want 1 cafe 700", IValidF, IRdataF, MemAddr); end
    step();
    IReqF    = 1'b0;
    MemReady = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    IReqF    = 1'b0;
    IAddrF   = '0;
    DReqM    = 1'b0;
    DWeM     = 1'b0;
    DAddrM   = '0;
    DWdataM  = '0;
    DByteEnM = '0;
    MemRdata = '0;
    MemReady = 1'b0;
    test_reset();
    test_idle_ready();
    test_single_fetch();
    test_store_wait();
    test_contention();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
